// File: rtl/stack_ctrl_if.sv
// Control bundle between the stack-machine FSM and its datapath.
`timescale 1ns/1ps
interface stack_ctrl_if;
    logic [2:0] OPC;
    logic       IorD;
    logic       memRead;
    logic       memWrite;
    logic       IRWrite;
    logic       SrcA;
    logic       SrcB;
    logic       LdA;
    logic       LdB;
    logic       PCWrite;
    logic       PCSrc;
    logic       tos;
    logic       Push;
    logic       Pop;
    logic       PCWriteCond;
    logic       MtoS;
    logic [1:0] AluOP;
    logic [3:0] state;

    modport master (
        input  OPC,
        output IorD, memRead, memWrite, IRWrite,
        output SrcA, SrcB, LdA, LdB,
        output PCWrite, PCSrc, tos, Push, Pop,
        output PCWriteCond, MtoS, AluOP, state
    );

    modport slave (
        output OPC,
        input  IorD, memRead, memWrite, IRWrite,
        input  SrcA, SrcB, LdA, LdB,
        input  PCWrite, PCSrc, tos, Push, Pop,
        input  PCWriteCond, MtoS, AluOP, state
    );
endinterface

// File: rtl/stack_ctrl.sv
// Multi-cycle Moore controller for a stack-machine datapath.
`timescale 1ns/1ps
module stack_ctrl (
    input  logic         clk,
    input  logic         rst,
    stack_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        ST_INIT  = 4'd0,
        ST_IF    = 4'd1,
        ST_ID    = 4'd2,
        ST_POPA  = 4'd3,
        ST_POPB  = 4'd4,
        ST_EXE   = 4'd5,
        ST_WB    = 4'd6,
        ST_MEMRD = 4'd7,
        ST_PUSHM = 4'd8,
        ST_MEMWR = 4'd9,
        ST_JMP   = 4'd10,
        ST_TOSZ  = 4'd11,
        ST_JZ    = 4'd12
    } state_e;

    logic [3:0] state_q;
    logic [3:0] state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_INIT;
        else      state_q <= state_d;
    end

    assign bus.state = state_q;

    always_comb begin
        state_d         = ST_INIT;
        bus.IorD        = 1'b0;
        bus.memRead     = 1'b0;
        bus.memWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.SrcA        = 1'b0;
        bus.SrcB        = 1'b0;
        bus.LdA         = 1'b0;
        bus.LdB         = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCSrc       = 1'b0;
        bus.tos         = 1'b0;
        bus.Push        = 1'b0;
        bus.Pop         = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.MtoS        = 1'b0;
        bus.AluOP       = 2'b00;
        case (state_q)
            ST_INIT: state_d = ST_IF;
            ST_IF: begin
                // PC <- PC + 1 while the instruction is fetched
                bus.memRead = 1'b1;
                bus.IRWrite = 1'b1;
                bus.SrcA    = 1'b1;
                bus.SrcB    = 1'b1;
                bus.PCWrite = 1'b1;
                state_d     = ST_ID;
            end
            ST_ID: begin
                unique case (1'b1)
                    bus.OPC == 3'b100: state_d = ST_MEMRD;
                    bus.OPC == 3'b110: state_d = ST_JMP;
                    bus.OPC == 3'b111: state_d = ST_TOSZ;
                    default:           state_d = ST_POPA;
                endcase
            end
            ST_POPA: begin
                bus.tos = 1'b1;
                bus.LdA = 1'b1;
                bus.Pop = 1'b1;
                unique case (1'b1)
                    bus.OPC == 3'b011: state_d = ST_EXE;
                    bus.OPC == 3'b101: state_d = ST_MEMWR;
                    default:           state_d = ST_POPB;
                endcase
            end
            ST_POPB: begin
                bus.tos = 1'b1;
                bus.LdB = 1'b1;
                bus.Pop = 1'b1;
                state_d = ST_EXE;
            end
            ST_EXE: begin
                bus.AluOP = bus.OPC[1:0];
                state_d   = ST_WB;
            end
            ST_WB: begin
                bus.Push = 1'b1;
                state_d  = ST_IF;
            end
            ST_MEMRD: begin
                bus.IorD    = 1'b1;
                bus.memRead = 1'b1;
                state_d     = ST_PUSHM;
            end
            ST_PUSHM: begin
                bus.Push = 1'b1;
                bus.MtoS = 1'b1;
                state_d  = ST_IF;
            end
            ST_MEMWR: begin
                bus.IorD     = 1'b1;
                bus.memWrite = 1'b1;
                state_d      = ST_IF;
            end
            ST_JMP: begin
                bus.PCWrite = 1'b1;
                bus.PCSrc   = 1'b1;
                state_d     = ST_IF;
            end
            ST_TOSZ: begin
                // Z samples the top of stack without popping it
                bus.tos = 1'b1;
                state_d = ST_JZ;
            end
            ST_JZ: begin
                bus.PCWriteCond = 1'b1;
                bus.PCSrc       = 1'b1;
                state_d         = ST_IF;
            end
            default: state_d = ST_INIT;
        endcase
    end
endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 The block SHALL have ports clk (input, 1, rising-edge clock) and rst (input, 1, reset); there is one clock, and reset is asynchronous and active-low.
REQ-002 The block SHALL have input OPC (3 bits): the instruction opcode, IR[7:5] from the datapath.
REQ-003 The block SHALL have these 1-bit outputs: IorD, memRead, memWrite, IRWrite, SrcA, SrcB, LdA, LdB, PCWrite, PCSrc, tos, Push, Pop, PCWriteCond, MtoS.
REQ-004 The block SHALL have output AluOP (2 bits): 00 add, 01 sub, 10 and, 11 not(inp1).
REQ-005 The block SHALL have output state (4 bits): the current FSM state, for debug and verification.
REQ-006 Datapath mux selects SHALL follow this convention: sel=0 picks inp1, sel=1 picks inp2.
- IorD: 0 = PC, 1 = IR[4:0].
- PCSrc: 0 = ALU, 1 = IR[4:0].
- SrcA: 0 = A, 1 = PC.
- SrcB: 0 = B, 1 = constant 1.
- MtoS: 0 = AluOut, 1 = MDR.

Function
REQ-007 The block SHALL be a Moore FSM: every output is decoded from state only, except AluOP in EXE, which equals {OPC[1:0]}.
REQ-008 State encoding SHALL be: INIT=0, IF=1, ID=2, POPA=3, POPB=4, EXE=5, WB=6, MEMRD=7, PUSHM=8, MEMWR=9, JMP=10, TOSZ=11, JZ=12.
REQ-009 Any output not listed for a state SHALL be 0.
REQ-010 INIT SHALL assert no outputs and go to IF.
REQ-011 IF SHALL assert memRead, IRWrite, SrcA, SrcB and PCWrite, with AluOP=00, IorD=0 and PCSrc=0 (PC <- PC+1), and go to ID.
REQ-012 ID SHALL assert no outputs and branch on OPC:
- 000, 001, 010, 011 -> POPA.
- 100 -> MEMRD.
- 101 -> POPA.
- 110 -> JMP.
- 111 -> TOSZ.
REQ-013 POPA SHALL assert tos, LdA and Pop; it goes to POPB if OPC is 000-010, to EXE if OPC=011, and to MEMWR if OPC=101.
REQ-014 POPB SHALL assert tos, LdB and Pop, and go to EXE.
REQ-015 EXE SHALL drive SrcA=0, SrcB=0 and AluOP=OPC[1:0] (AluOut captures the result at the next edge), and go to WB.
REQ-016 WB SHALL assert Push with MtoS=0, and go to IF.
REQ-017 MEMRD SHALL assert IorD and memRead (MDR captures the data), and go to PUSHM.
REQ-018 PUSHM SHALL assert Push and MtoS, and go to IF.
REQ-019 MEMWR SHALL assert IorD and memWrite (memory[IR[4:0]] <- A), and go to IF.
REQ-020 JMP SHALL assert PCWrite and PCSrc, and go to IF.
REQ-021 TOSZ SHALL assert tos (the Z register captures the top of stack; the stack is not popped), and go to JZ.
REQ-022 JZ SHALL assert PCWriteCond and PCSrc, and go to IF.
REQ-023 Instruction latencies, measured from entering IF, SHALL be: ADD/SUB/AND 6 cycles, NOT 5, PUSH 4, POP 4, JMP 3, JZ 4.
REQ-024 Push and Pop SHALL never be asserted in the same cycle.
REQ-025 memRead and memWrite SHALL never be asserted in the same cycle.
REQ-026 PCWrite and PCWriteCond SHALL never be asserted in the same cycle.
REQ-027 OPC SHALL be sampled only in ID, POPA and EXE; OPC changes in any other state SHALL have no effect.
REQ-028 The unused encodings 13-15 SHALL drive all outputs 0 and go to INIT on the next edge.

Reset
REQ-029 When rst=0, the FSM SHALL enter INIT immediately (asynchronously), with state=0 and all outputs 0, regardless of the current state.
REQ-030 While rst=0, the FSM SHALL hold INIT.
REQ-031 The first rising edge with rst=1 SHALL move the FSM to IF.
REQ-032 If reset is asserted mid-instruction (e.g. in POPB or MEMWR), the instruction SHALL be aborted with no further Push, Pop or memWrite issued.

Verification
REQ-033 The bench SHALL cover reset: rst=0 for 2 cycles, then released -> state=0 with all outputs 0 during reset, state=1 one edge after release, and IF outputs as in REQ-011.
REQ-034 The bench SHALL cover ADD: OPC=000 -> state sequence 1,2,3,4,5,6,1; AluOP=00 in EXE; exactly 2 Pop pulses and 1 Push pulse (MtoS=0).
REQ-035 The bench SHALL cover SUB and NOT:
- OPC=001 -> AluOP=01 in EXE.
- OPC=011 -> sequence 1,2,3,5,6,1 with AluOP=11 and exactly 1 Pop.
REQ-036 The bench SHALL cover PUSH and POP:
- OPC=100 -> sequence 1,2,7,8,1; IorD=memRead=1 in state 7; Push=MtoS=1 in state 8.
- OPC=101 -> sequence 1,2,3,9,1; memWrite=IorD=1 in state 9.
REQ-037 The bench SHALL cover JMP and JZ:
- OPC=110 -> sequence 1,2,10,1; PCWrite=PCSrc=1 in state 10.
- OPC=111 -> sequence 1,2,11,12,1; tos=1 with Pop=0 in state 11; PCWriteCond=PCSrc=1 with PCWrite=0 in state 12.
REQ-038 The bench SHALL cover mid-operation reset and illegal state:
- rst=0 asserted while in state 4 -> immediate state=0, no Pop afterwards.
- Forced state=14 -> all outputs 0, next state 0.
